// File: rtl/multiword_adder_seq.sv
// Sequential wide adder: one N-bit ripple stage reused per chunk, LSB first; result WORDS cycles after accept, held until out_ready.
// in_ready only in IDLE (no accept/output overlap); `MWADD_OVERFLOW_EN adds a registered signed-overflow output ovf.

module rca_nbit #(
   parameter int N = 4
) (
   input  logic [N-1:0] x,
   input  logic [N-1:0] y,
   input  logic         c_in,
   output logic [N-1:0] s,
   output logic         c_out
);
   logic [N:0] c;

   always_comb begin
      c    = '0;
      s    = '0;
      c[0] = c_in;
      for (int i = 0; i < N; i++) begin
         s[i]   = x[i] ^ y[i] ^ c[i];
         c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
      end
      c_out = c[N];
   end
endmodule

module multiword_adder_seq #(
   parameter int N     = 4,
   parameter int WORDS = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [N*WORDS-1:0]   a,
   input  logic [N*WORDS-1:0]   b,
   input  logic                 c_in,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [N*WORDS-1:0]   sum,
   output logic                 c_out,
`ifdef MWADD_OVERFLOW_EN
   output logic                 ovf,
`endif
   output logic                 busy
);
   localparam int W  = N * WORDS;
   localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   a_q, a_d;
   logic [W-1:0]   b_q, b_d;
   logic [W-1:0]   sum_q, sum_d;
   logic           carry_q, carry_d;
   logic [KW-1:0]  k_q, k_d;
   logic           cout_q, cout_d;
   logic           ovld_q, ovld_d;
`ifdef MWADD_OVERFLOW_EN
   logic           a_msb_q, a_msb_d;
   logic           b_msb_q, b_msb_d;
   logic           ovf_q, ovf_d;
`endif

   logic           accept;
   logic           last_chunk;
   logic [N-1:0]   rca_s;
   logic           rca_c;

   rca_nbit #(.N(N)) u_rca (
      .x     (a_q[N-1:0]),
      .y     (b_q[N-1:0]),
      .c_in  (carry_q),
      .s     (rca_s),
      .c_out (rca_c)
   );

   assign accept     = in_valid && in_ready;
   assign last_chunk = (state_q == RUN) && (k_q == KW'(WORDS - 1));

   // FSM: state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid)  state_d = RUN;
         RUN:     if (last_chunk) state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM: state-decoded outputs
   always_comb begin
      in_ready = 1'b0;
      busy     = 1'b0;
      case (state_q)
         IDLE:    in_ready = 1'b1;
         RUN:     busy     = 1'b1;
         DONE:    busy     = 1'b1;
         default: in_ready = 1'b0;
      endcase
   end

   // Datapath next state
   always_comb begin
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      k_d     = k_q;
      cout_d  = cout_q;
      ovld_d  = ovld_q;
`ifdef MWADD_OVERFLOW_EN
      a_msb_d = a_msb_q;
      b_msb_d = b_msb_q;
      ovf_d   = ovf_q;
`endif
      if (accept) begin
         a_d     = a;
         b_d     = b;
         carry_d = c_in;
         k_d     = '0;
`ifdef MWADD_OVERFLOW_EN
         a_msb_d = a[W-1];
         b_msb_d = b[W-1];
`endif
      end else if (state_q == RUN) begin
         // New chunk enters at the top so after WORDS shifts chunk 0 sits at the bottom.
         sum_d   = (sum_q >> N) | (W'(rca_s) << (W - N));
         a_d     = a_q >> N;
         b_d     = b_q >> N;
         carry_d = rca_c;
         if (last_chunk) begin
            cout_d = rca_c;
            ovld_d = 1'b1;
`ifdef MWADD_OVERFLOW_EN
            ovf_d  = (a_msb_q == b_msb_q) && (rca_s[N-1] != a_msb_q);
`endif
         end else begin
            k_d = k_q + KW'(1);
         end
      end else if ((state_q == DONE) && out_ready) begin
         ovld_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         k_q     <= '0;
         cout_q  <= 1'b0;
         ovld_q  <= 1'b0;
`ifdef MWADD_OVERFLOW_EN
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
         ovf_q   <= 1'b0;
`endif
      end else begin
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         k_q     <= k_d;
         cout_q  <= cout_d;
         ovld_q  <= ovld_d;
`ifdef MWADD_OVERFLOW_EN
         a_msb_q <= a_msb_d;
         b_msb_q <= b_msb_d;
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign sum       = sum_q;
   assign c_out     = cout_q;
   assign out_valid = ovld_q;
`ifdef MWADD_OVERFLOW_EN
   assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_multiword_adder_seq.sv
// Bench for multiword_adder_seq at N=4, WORDS=4: vector table, hand-written corner sequences, random back-to-back traffic.
module tb_multiword_adder_seq;
   localparam int N     = 4;
   localparam int WORDS = 4;
   localparam int W     = N * WORDS;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          c_in;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  sum;
   logic          c_out;
   logic          busy;
`ifdef MWADD_OVERFLOW_EN
   logic          ovf;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   multiword_adder_seq #(.N(N), .WORDS(WORDS)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .c_in      (c_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .c_out     (c_out),
`ifdef MWADD_OVERFLOW_EN
      .ovf       (ovf),
`endif
      .busy      (busy)
   );

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         ci;
      logic [W-1:0] s;
      logic         co;
      logic         ov;
   } vec_t;

   vec_t tbl[9];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: plain wide arithmetic and the signed-overflow rule
   function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
      return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
   endfunction

   function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] s);
      return (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
   endfunction

   // One transaction with out_ready held high.
   task automatic run_txn(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic ci, input logic [W-1:0] es, input logic eco, input logic eov);
      int n;
      out_ready = 1'b1;
      a = av; b = bv; c_in = ci; in_valid = 1'b1;
      chk({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      a = W'($urandom); b = W'($urandom); c_in = 1'($urandom);
      n = 0;
      while (!out_valid && n < 40) begin
         tick();
         n++;
      end
      chk({tag, "_latency"}, 32'(n), 32'(WORDS));
      chk({tag, "_sum"}, 32'(sum), 32'(es));
      chk({tag, "_cout"}, 32'(c_out), 32'(eco));
`ifdef MWADD_OVERFLOW_EN
      chk({tag, "_ovf"}, 32'(ovf), 32'(eov));
`else
      if (eov === 1'bx) chk({tag, "_ovf_vec"}, 32'(eov), 32'd0);
`endif
      tick();
      chk({tag, "_ovalid_drop"}, 32'(out_valid), 32'd0);
      chk({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
      chk({tag, "_sum_kept"}, 32'(sum), 32'(es));
   endtask

   initial begin
      logic [W-1:0] ra[8];
      logic [W-1:0] rb[8];
      logic         rc[8];
      logic [W:0]   expq[$];
      logic [W:0]   r;
      int           n, nxt, got, cyc, last_acc;
      logic         acc;

      tbl[0] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0};
      tbl[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
      tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
      tbl[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
      tbl[4] = '{16'h0005, 16'hFFFE, 1'b0, 16'h0003, 1'b1, 1'b0};
      tbl[5] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
      tbl[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
      tbl[7] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
      tbl[8] = '{16'h5555, 16'hAAAA, 1'b1, 16'h0000, 1'b1, 1'b0};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; c_in = 1'b0;
      tick(); tick();
      rst = 1'b0;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_cout", 32'(c_out), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef MWADD_OVERFLOW_EN
      chk("rst_ovf", 32'(ovf), 32'd0);
`endif

      for (int i = 0; i < 9; i++) begin
         run_txn($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].s, tbl[i].co, tbl[i].ov);
      end

      // Backpressure: result held, in_valid noise ignored while busy
      out_ready = 1'b0;
      a = 16'hABCD; b = 16'h0101; c_in = 1'b0; in_valid = 1'b1;
      tick();
      a = 16'hFFFF; b = 16'hFFFF; c_in = 1'b1;
      n = 0;
      while (!out_valid && n < 40) begin
         chk("bp_in_ready_run", 32'(in_ready), 32'd0);
         chk("bp_busy_run", 32'(busy), 32'd1);
         in_valid = ~in_valid;
         tick();
         n++;
      end
      chk("bp_latency", 32'(n), 32'(WORDS));
      for (int i = 0; i < 6; i++) begin
         chk("bp_sum_held", 32'(sum), 32'h0000ACCE);
         chk("bp_cout_held", 32'(c_out), 32'd0);
         chk("bp_ovalid_held", 32'(out_valid), 32'd1);
         chk("bp_in_ready_done", 32'(in_ready), 32'd0);
         in_valid = ~in_valid;
         tick();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      tick();
      chk("bp_release_ovalid", 32'(out_valid), 32'd0);
      chk("bp_release_in_ready", 32'(in_ready), 32'd1);
      chk("bp_release_sum", 32'(sum), 32'h0000ACCE);

      // Reset during RUN abandons the transaction
      a = 16'hFFFF; b = 16'hFFFF; c_in = 1'b1; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_sum", 32'(sum), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      chk("midrst_busy", 32'(busy), 32'd0);
      run_txn("post_rst", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);

      // Random single transactions against the model
      for (int i = 0; i < 10; i++) begin
         logic [W-1:0] x, y;
         logic         ci;
         x = W'($urandom); y = W'($urandom); ci = 1'($urandom);
         r = ref_add(x, y, ci);
         run_txn($sformatf("rnd%0d", i), x, y, ci, r[W-1:0], r[W], ref_ovf(x, y, r[W-1:0]));
      end

      // Back-to-back with in_valid and out_ready held high
      for (int i = 0; i < 8; i++) begin
         ra[i] = W'($urandom); rb[i] = W'($urandom); rc[i] = 1'($urandom);
      end
      nxt = 0; got = 0; cyc = 0; last_acc = -1;
      out_ready = 1'b1;
      a = ra[0]; b = rb[0]; c_in = rc[0]; in_valid = 1'b1;
      while (got < 8 && cyc < 300) begin
         acc = in_valid && in_ready;
         tick();
         cyc++;
         if (acc) begin
            expq.push_back(ref_add(ra[nxt], rb[nxt], rc[nxt]));
            if (last_acc >= 0) chk("b2b_accept_interval", 32'(cyc - last_acc), 32'(WORDS + 2));
            last_acc = cyc;
            nxt++;
            if (nxt < 8) begin
               a = ra[nxt]; b = rb[nxt]; c_in = rc[nxt];
            end else begin
               in_valid = 1'b0;
            end
         end
         if (out_valid) begin
            if (expq.size() == 0) begin
               chk("b2b_unexpected_result", 32'd1, 32'd0);
            end else begin
               r = expq.pop_front();
               chk("b2b_result", 32'({c_out, sum}), 32'(r));
            end
            got++;
         end
      end
      chk("b2b_result_count", 32'(got), 32'd8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
